// File: rtl/vga_fb_pkg.sv
// Shared definitions for the frame-buffer readers in the clk_vga domain.
package vga_fb_pkg;

   localparam int IMG_WIDTH_DEF  = 320;
   localparam int IMG_HEIGHT_DEF = 240;
   localparam int PIX_PER_FRAME  = IMG_WIDTH_DEF * IMG_HEIGHT_DEF;

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      FETCH,
      DRAIN
   } fetch_state_t;

   // Pixels per frame for an arbitrary image geometry.
   function automatic int pix_per_frame(input int width, input int height);
      return width * height;
   endfunction

endpackage

// File: rtl/fb_read_pipe.sv
// Valid-bit delay line matching a fixed-latency RAM read path.
// out_valid rises exactly LATENCY cycles after the in_valid that caused it.
module fb_read_pipe #(
   parameter int LATENCY = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic flush,
   input  logic in_valid,
   output logic out_valid
);

   logic [LATENCY-1:0] stage;

   // Shift the valid bit along; flush drops every read still in the RAM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage <= '0;
      end else if (flush) begin
         stage <= '0;
      end else begin
         stage[0] <= in_valid;
         for (int unsigned i = 1; i < LATENCY; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign out_valid = stage[LATENCY-1];

endmodule

// File: rtl/vga_frame_prefetcher.sv
// Writer side of the display pixel FIFO: streams one frame from the
// frame-buffer RAM into the FIFO during vertical blanking, throttled by
// FIFO occupancy so pixel 0 sits at the FIFO head when active video starts.
module vga_frame_prefetcher
   import vga_fb_pkg::*;
#(
   parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
   parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
   parameter int ADDR_W     = 17,
   parameter int DATA_W     = 16,
   parameter int RD_LATENCY = 2,
   parameter int FIFO_DEPTH = 512,
   parameter int CNT_W      = 10
) (
   input  logic              clk_vga,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              fetch_start,
   input  logic [ADDR_W-1:0] fb_base,
   output logic              fb_rd_en,
   output logic [ADDR_W-1:0] fb_addr,
   input  logic [DATA_W-1:0] fb_rd_data,
   output logic              fifo_clr,
   output logic              fifo_wr_en,
   output logic [DATA_W-1:0] fifo_wr_data,
   input  logic              fifo_full,
   input  logic [CNT_W-1:0]  fifo_count,
   output logic              busy,
   output logic              frame_done,
   output logic              overflow_err,
   output logic              resync_err
);

   localparam int N_PIX = pix_per_frame(IMG_WIDTH, IMG_HEIGHT);
   localparam int PIX_W = $clog2(N_PIX + 1);
   localparam int INF_W = $clog2(RD_LATENCY + 2);

   fetch_state_t      state;
   fetch_state_t      state_nxt;
   logic [ADDR_W-1:0] base;
   logic [PIX_W-1:0]  pix_cnt;
   logic [INF_W-1:0]  inflight;
   logic              accept;
   logic              issue;
   logic              last_issue;
   logic              pipe_out;

   // An enabled start is honoured in every state; outside IDLE it aborts.
   assign accept = fetch_start && enable;
   assign busy   = (state != IDLE);

   // fifo_count lags by one cycle, so one slot is held back as margin.
   assign issue = (state == FETCH) &&
                  ((32'(fifo_count) + 32'(inflight)) < 32'(FIFO_DEPTH - 1));
   assign last_issue = issue && (pix_cnt == PIX_W'(N_PIX - 1));

   assign fb_rd_en = issue;
   assign fb_addr  = base + ADDR_W'(pix_cnt);

   fb_read_pipe #(
      .LATENCY (RD_LATENCY)
   ) u_read_pipe (
      .clk       (clk_vga),
      .rst_n     (rst_n),
      .flush     (accept),
      .in_valid  (issue),
      .out_valid (pipe_out)
   );

   assign fifo_wr_en   = pipe_out;
   assign fifo_wr_data = pipe_out ? fb_rd_data : '0;

   // State register.
   always_ff @(posedge clk_vga or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state selection plus the clear and frame-done strobes.
   always_comb begin
      state_nxt  = state;
      fifo_clr   = 1'b0;
      frame_done = 1'b0;
      case (state)
         IDLE: begin
            if (accept) state_nxt = CLEAR;
         end
         CLEAR: begin
            fifo_clr  = 1'b1;
            state_nxt = accept ? CLEAR : FETCH;
         end
         FETCH: begin
            if (accept)          state_nxt = CLEAR;
            else if (last_issue) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (accept) begin
               state_nxt = CLEAR;
            end else if (inflight == '0) begin
               frame_done = 1'b1;
               state_nxt  = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Base latch, pixel/in-flight counters and sticky error flags.
   always_ff @(posedge clk_vga or negedge rst_n) begin
      if (!rst_n) begin
         base         <= '0;
         pix_cnt      <= '0;
         inflight     <= '0;
         overflow_err <= 1'b0;
         resync_err   <= 1'b0;
      end else begin
         if (accept) begin
            base     <= fb_base;
            pix_cnt  <= '0;
            inflight <= '0;
            if (state != IDLE) resync_err <= 1'b1;
         end else begin
            if (issue) pix_cnt <= pix_cnt + 1'b1;
            case ({issue, pipe_out})
               2'b10:   inflight <= inflight + 1'b1;
               2'b01:   inflight <= inflight - 1'b1;
               default: inflight <= inflight;
            endcase
         end
         if (pipe_out && fifo_full) overflow_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_vga_frame_prefetcher.sv
// Directed-sequence bench for vga_frame_prefetcher with a hashed RAM model,
// an occupancy-tracking FIFO model and an in-order expected-pixel scoreboard.
module tb_vga_frame_prefetcher;

   localparam int IMG_W  = 40;
   localparam int IMG_H  = 30;
   localparam int N      = IMG_W * IMG_H;
   localparam int ADDR_W = 17;
   localparam int DATA_W = 16;
   localparam int RD_LAT = 2;
   localparam int DEPTH  = 512;
   localparam int CNT_W  = 10;

   logic              clk_vga     = 1'b0;
   logic              rst_n       = 1'b0;
   logic              enable      = 1'b0;
   logic              fetch_start = 1'b0;
   logic [ADDR_W-1:0] fb_base     = '0;
   logic              fb_rd_en;
   logic [ADDR_W-1:0] fb_addr;
   logic [DATA_W-1:0] fb_rd_data;
   logic              fifo_clr;
   logic              fifo_wr_en;
   logic [DATA_W-1:0] fifo_wr_data;
   logic              fifo_full   = 1'b0;
   logic [CNT_W-1:0]  fifo_count  = '0;
   logic              busy;
   logic              frame_done;
   logic              overflow_err;
   logic              resync_err;

   vga_frame_prefetcher #(
      .IMG_WIDTH  (IMG_W),
      .IMG_HEIGHT (IMG_H),
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .RD_LATENCY (RD_LAT),
      .FIFO_DEPTH (DEPTH),
      .CNT_W      (CNT_W)
   ) dut (
      .clk_vga      (clk_vga),
      .rst_n        (rst_n),
      .enable       (enable),
      .fetch_start  (fetch_start),
      .fb_base      (fb_base),
      .fb_rd_en     (fb_rd_en),
      .fb_addr      (fb_addr),
      .fb_rd_data   (fb_rd_data),
      .fifo_clr     (fifo_clr),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_wr_data (fifo_wr_data),
      .fifo_full    (fifo_full),
      .fifo_count   (fifo_count),
      .busy         (busy),
      .frame_done   (frame_done),
      .overflow_err (overflow_err),
      .resync_err   (resync_err)
   );

   always #20 clk_vga = ~clk_vga;

   // ---------------- RAM model: content is a salted hash of the address
   logic [15:0] salt;

   function automatic logic [DATA_W-1:0] ram_word(input logic [ADDR_W-1:0] a);
      logic [31:0] x;
      x = 32'(a) * 32'd2654435761;
      return x[31:16] ^ salt;
   endfunction

   logic [DATA_W-1:0] rd_delay [RD_LAT];

   // Read data appears RD_LAT cycles after the strobe; junk otherwise.
   always @(posedge clk_vga) begin
      rd_delay[0] <= fb_rd_en ? ram_word(fb_addr) : DATA_W'($urandom);
      for (int i = 1; i < RD_LAT; i++) rd_delay[i] <= rd_delay[i-1];
   end
   assign fb_rd_data = rd_delay[RD_LAT-1];

   // ---------------- FIFO model: popped every other cycle, registered count
   int   occ       = 0;
   int   ovf_model = 0;
   bit   pop_phase = 1'b0;
   bit   force_cnt = 1'b0;
   bit   force_full = 1'b0;
   int   forced_cnt = 0;

   always @(posedge clk_vga) begin
      int o;
      o = occ;
      if (fifo_clr) begin
         o = 0;
      end else begin
         if (fifo_wr_en) begin
            if (o < DEPTH) o = o + 1;
            else ovf_model = ovf_model + 1;
         end
         if (pop_phase && o > 0) o = o - 1;
      end
      pop_phase = !pop_phase;
      occ = o;
      fifo_count <= force_cnt ? CNT_W'(forced_cnt) : CNT_W'(o);
      fifo_full  <= force_full || (o == DEPTH);
   end

   // ---------------- Monitor / scoreboard: frame k-th write must be RAM[base+k]
   logic [ADDR_W-1:0] pend_base = '0;
   logic [ADDR_W-1:0] cur_base  = '0;
   logic [ADDR_W-1:0] addr16    = '1;
   logic [DATA_W-1:0] first_wr_data = '0;
   int wr_idx = 0, rd_idx = 0, wr_total = 0, rd_total = 0;
   int data_err = 0, addr_err = 0, done_cnt = 0, clr_cnt = 0, done_wr = 0;

   always @(negedge clk_vga) begin
      if (fifo_clr) begin
         clr_cnt  = clr_cnt + 1;
         cur_base = pend_base;
         wr_idx   = 0;
         rd_idx   = 0;
      end
      if (fb_rd_en) begin
         if (fb_addr !== ADDR_W'(cur_base + rd_idx)) addr_err = addr_err + 1;
         if (rd_idx == 16) addr16 = fb_addr;
         rd_idx   = rd_idx + 1;
         rd_total = rd_total + 1;
      end
      if (fifo_wr_en) begin
         if (wr_idx == 0) first_wr_data = fifo_wr_data;
         if (fifo_wr_data !== ram_word(ADDR_W'(cur_base + wr_idx))) data_err = data_err + 1;
         wr_idx   = wr_idx + 1;
         wr_total = wr_total + 1;
      end
      if (frame_done) begin
         done_cnt = done_cnt + 1;
         done_wr  = wr_idx;
      end
   end

   // ---------------- Checking helpers
   int checks = 0;
   int passed = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk_vga);
      #1;
   endtask

   task automatic start_frame(input logic [ADDR_W-1:0] b, input bit en);
      @(posedge clk_vga); #1;
      enable  = en;
      fb_base = b;
      if (en) pend_base = b;
      fetch_start = 1'b1;
      @(posedge clk_vga); #1;
      fetch_start = 1'b0;
   endtask

   task automatic wait_done(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk_vga);
         if (frame_done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_writes(input int target, input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk_vga); #1;
         if (wr_idx >= target) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // ---------------- Directed sequence
   bit                ok;
   logic [ADDR_W-1:0] b;
   int                r0, w0, c0, d0, maxo, o;

   initial begin
      salt = 16'($urandom);

      // Reset state
      cycles(3);
      check("rst_busy", busy, 0);
      check("rst_rd_en", fb_rd_en, 0);
      check("rst_addr", fb_addr, 0);
      check("rst_clr", fifo_clr, 0);
      check("rst_wr_en", fifo_wr_en, 0);
      check("rst_wr_data", fifo_wr_data, 0);
      check("rst_done", frame_done, 0);
      check("rst_ovf", overflow_err, 0);
      check("rst_resync", resync_err, 0);
      rst_n = 1'b1;
      cycles(2);

      // Full frame from base 0 against the draining FIFO model
      start_frame('0, 1'b1);
      check("a_busy", busy, 1);
      wait_done(20000, ok);
      check("a_done_seen", ok, 1);
      cycles(5);
      check("a_writes", done_wr, N);
      check("a_total", wr_idx, N);
      check("a_data_err", data_err, 0);
      check("a_addr_err", addr_err, 0);
      check("a_done_pulses", done_cnt, 1);
      check("a_clr_pulses", clr_cnt, 1);
      check("a_ovf", overflow_err, 0);
      check("a_resync", resync_err, 0);
      check("a_model_ovf", ovf_model, 0);
      check("a_idle", busy, 0);

      // Start with enable low is ignored
      start_frame(17'h0ABCD, 1'b0);
      cycles(3);
      check("en_low_busy", busy, 0);
      check("en_low_clr", clr_cnt, 1);

      // Occupancy throttle
      enable     = 1'b1;
      force_cnt  = 1'b1;
      forced_cnt = 511;
      b = ADDR_W'($urandom);
      start_frame(b, 1'b1);
      cycles(30);
      check("b_no_reads_511", rd_idx, 0);
      forced_cnt = 510;
      r0 = rd_total; maxo = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk_vga); #1;
         o = rd_idx - wr_idx;
         if (o > maxo) maxo = o;
      end
      check("b_outstanding_510", maxo, 1);
      check("b_reads_510", 32'((rd_total - r0 >= 9) && (rd_total - r0 <= 11)), 1);
      forced_cnt = 400;
      r0 = rd_total; maxo = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk_vga); #1;
         o = rd_idx - wr_idx;
         if (o > maxo) maxo = o;
      end
      check("b_outstanding_400", maxo, RD_LAT);
      check("b_reads_400", 32'(rd_total - r0 >= 28), 1);
      force_cnt = 1'b0;
      d0 = done_cnt;
      wait_done(20000, ok);
      check("b_done_seen", ok, 1);
      cycles(5);
      check("b_writes", done_wr, N);
      check("b_data_err", data_err, 0);
      check("b_addr_err", addr_err, 0);
      check("b_done_pulses", done_cnt - d0, 1);
      check("b_ovf", overflow_err, 0);
      check("b_model_ovf", ovf_model, 0);

      // Address wrap; enable dropped mid-frame must not matter
      start_frame(17'h1FFF0, 1'b1);
      enable = 1'b0;
      wait_done(20000, ok);
      check("c_done_seen", ok, 1);
      cycles(5);
      check("c_wrap_addr", addr16, 0);
      check("c_writes", done_wr, N);
      check("c_data_err", data_err, 0);
      check("c_addr_err", addr_err, 0);

      // Abort and resync
      b = ADDR_W'($urandom);
      start_frame(b, 1'b1);
      wait_writes(1000, 5000, ok);
      check("d_reached_1000", ok, 1);
      c0 = clr_cnt;
      start_frame(17'h12C00, 1'b1);
      check("d_resync_set", resync_err, 1);
      wait_done(20000, ok);
      check("d_done_seen", ok, 1);
      cycles(5);
      check("d_clr_pulses", clr_cnt - c0, 1);
      check("d_first_word", first_wr_data, ram_word(17'h12C00));
      check("d_writes", done_wr, N);
      check("d_data_err", data_err, 0);
      check("d_resync_sticky", resync_err, 1);

      // Write while full
      b = ADDR_W'($urandom);
      start_frame(b, 1'b1);
      wait_writes(50, 2000, ok);
      check("e_reached_50", ok, 1);
      force_full = 1'b1;
      cycles(10);
      force_full = 1'b0;
      check("e_ovf_set", overflow_err, 1);
      cycles(20);
      check("e_ovf_sticky", overflow_err, 1);
      wait_done(20000, ok);
      check("e_done_seen", ok, 1);
      cycles(5);
      check("e_ovf_after_frame", overflow_err, 1);
      check("e_data_err", data_err, 0);

      // Reset mid-FETCH with two reads outstanding
      b = ADDR_W'($urandom);
      start_frame(b, 1'b1);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk_vga); #1;
         if (wr_idx >= 3 && (rd_idx - wr_idx) == 2) begin
            ok = 1'b1;
            break;
         end
      end
      check("f_two_in_flight", ok, 1);
      rst_n = 1'b0;
      #1;
      check("f_busy", busy, 0);
      check("f_rd_en", fb_rd_en, 0);
      check("f_addr", fb_addr, 0);
      check("f_wr_en", fifo_wr_en, 0);
      check("f_wr_data", fifo_wr_data, 0);
      check("f_clr", fifo_clr, 0);
      check("f_ovf", overflow_err, 0);
      check("f_resync", resync_err, 0);
      w0 = wr_total; r0 = rd_total;
      cycles(2);
      rst_n = 1'b1;
      cycles(20);
      check("f_no_writes", wr_total - w0, 0);
      check("f_no_reads", rd_total - r0, 0);
      check("f_idle", busy, 0);

      // Clean frame after reset
      start_frame(17'h00100, 1'b1);
      wait_done(20000, ok);
      check("g_done_seen", ok, 1);
      cycles(5);
      check("g_writes", done_wr, N);
      check("g_data_err", data_err, 0);
      check("g_addr_err", addr_err, 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
